sys_ctrl: RTL

Command sequencer between the UART receive path and the register file. Parses byte frames delivered by the UART RX (write or read commands), drives single-cycle register-file accesses, and returns read data through the UART TX with a busy/valid handshake. Sits at system top level, one instance per UART link.

---
 rtl/sys_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl
//   Command sequencer between a UART receive path and a register file.
//   Frames:  write = 0xAA, ADDR, DATA      read = 0xBB, ADDR  (one byte back on TX)
//   A bad command byte, a byte arriving while a read is outstanding, or an
//   inter-byte / read-data timeout produces a one-cycle CMD_ERR pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE    | waiting for a command byte (0xAA / 0xBB)
//   S_WR_ADDR | write frame, waiting for the address byte
//   S_WR_DATA | write frame, waiting for the data byte
//   S_RD_ADDR | read frame, waiting for the address byte
//   S_RD_WAIT | read strobe issued, waiting for RF_RdData_VLD
//   S_TX_SEND | read data captured, waiting for TX_BUSY low to send it
//
// Ports
//   clk, rst                 system clock, asynchronous active-low reset
//   RX_P_DATA / RX_D_VLD     received byte and its one-cycle valid pulse
//   RF_Address               register-file address (registered)
//   RF_WrEn / RF_WrData      one-cycle write strobe and write data
//   RF_RdEn                  one-cycle read strobe
//   RF_RdData / _VLD         read data and its valid pulse
//   TX_P_DATA / TX_D_VLD     byte to transmit and one-cycle transmit request
//   TX_BUSY                  transmitter busy, TX_D_VLD withheld while high
//   CMD_ERR                  one-cycle frame-error pulse
// -----------------------------------------------------------------------------
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_RdEn,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4,
        S_TX_SEND = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      to_cnt, to_cnt_nxt;
    logic                  counting;
    logic                  timed_out;
    logic [ADDR_WIDTH-1:0] rx_addr;

    logic                  wr_en_nxt, rd_en_nxt, tx_vld_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, tx_data_nxt;

    assign rx_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
    assign counting = (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                      (state == S_RD_ADDR) || (state == S_RD_WAIT);
    // This is the TIMEOUT-th quiet cycle in the current state.
    assign timed_out = counting && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (RX_D_VLD && (RX_P_DATA == CMD_WR))
                    state_nxt = S_WR_ADDR;
                else if (RX_D_VLD && (RX_P_DATA == CMD_RD))
                    state_nxt = S_RD_ADDR;
            end
            S_WR_ADDR: begin
                if (RX_D_VLD)       state_nxt = S_WR_DATA;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_WR_DATA: begin
                if (RX_D_VLD || timed_out) state_nxt = S_IDLE;
            end
            S_RD_ADDR: begin
                if (RX_D_VLD)       state_nxt = S_RD_WAIT;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_RD_WAIT: begin
                // A stray RX byte here is dropped and does not restart the timer.
                if (RF_RdData_VLD)  state_nxt = S_TX_SEND;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_TX_SEND: begin
                if (!TX_BUSY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Every accepted byte moves the FSM, so clearing on state change
        // also covers clearing on an accepted byte.
        to_cnt_nxt = '0;
        if (counting && (state_nxt == state))
            to_cnt_nxt = to_cnt + 1'b1;
    end

    always_comb begin
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_nxt     = 1'b0;
        addr_nxt    = RF_Address;
        wdata_nxt   = RF_WrData;
        tx_data_nxt = TX_P_DATA;
        case (state)
            S_IDLE: begin
                err_nxt = RX_D_VLD && (RX_P_DATA != CMD_WR) && (RX_P_DATA != CMD_RD);
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) addr_nxt = rx_addr;
                else          err_nxt  = timed_out;
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_nxt = 1'b1;
                    wdata_nxt = RX_P_DATA;
                end else begin
                    err_nxt = timed_out;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = rx_addr;
                    rd_en_nxt = 1'b1;
                end else begin
                    err_nxt = timed_out;
                end
            end
            S_RD_WAIT: begin
                err_nxt = RX_D_VLD || (!RF_RdData_VLD && timed_out);
                if (RF_RdData_VLD) tx_data_nxt = RF_RdData;
            end
            S_TX_SEND: begin
                err_nxt    = RX_D_VLD;
                tx_vld_nxt = !TX_BUSY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RF_Address <= '0;
            RF_WrEn    <= 1'b0;
            RF_WrData  <= '0;
            RF_RdEn    <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            RF_Address <= addr_nxt;
            RF_WrEn    <= wr_en_nxt;
            RF_WrData  <= wdata_nxt;
            RF_RdEn    <= rd_en_nxt;
            TX_P_DATA  <= tx_data_nxt;
            TX_D_VLD   <= tx_vld_nxt;
            CMD_ERR    <= err_nxt;
        end
    end

endmodule
